lcd_timing_gen: RTL and testbench

// Parametrised LCD timing generator with show-ahead pixel-queue reader. Replaces the fixed 480x272 timing

---
 rtl/lcd_timing_gen.sv | 156 +++++++++++++++
 tb/tb_lcd_timing_gen.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// LCD timing generator: parametrised DE/HSYNC/VSYNC raster with a show-ahead pixel-queue reader,
// frame-marker realignment, underflow blanking and a colour-bar test pattern.
module lcd_timing_gen #(
   parameter int H_ACTIVE  = 480,
   parameter int H_FP      = 8,
   parameter int H_SYNC    = 4,
   parameter int H_BP      = 43,
   parameter int V_ACTIVE  = 272,
   parameter int V_FP      = 8,
   parameter int V_SYNC    = 4,
   parameter int V_BP      = 12,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int CNT_W     = 11
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        pattern_en,
   input  logic        clear_status,
   input  logic [16:0] queue_data,
   input  logic        queue_empty,
   output logic        queue_rd_en,
   output logic        LCD_DE,
   output logic        LCD_HSYNC,
   output logic        LCD_VSYNC,
   output logic [4:0]  LCD_R,
   output logic [5:0]  LCD_G,
   output logic [4:0]  LCD_B,
   output logic        frame_start,
   output logic        underflow,
   output logic        sync_err
);

   // state  | meaning
   // RESYNC | black on active pixels; discard words until the frame marker is at the head
   // RUN    | active pixels pop and display the queue head
   typedef enum logic {ST_RESYNC, ST_RUN} state_t;

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BAR_W   = H_ACTIVE / 8;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] h_cnt, v_cnt, bar_px;
   logic [2:0]       bar_idx;
   logic             pat_q;

   logic             h_last, v_last, at_origin, active, hs_act, vs_act;
   logic             pat_mode, marker, run_now, pop, set_uf, set_se;
   logic [15:0]      pix, bar_color;

   assign h_last    = (h_cnt == CNT_W'(H_TOTAL - 1));
   assign v_last    = (v_cnt == CNT_W'(V_TOTAL - 1));
   assign at_origin = (h_cnt == '0) && (v_cnt == '0);
   assign active    = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
   assign hs_act    = (h_cnt >= CNT_W'(H_ACTIVE + H_FP)) && (h_cnt < CNT_W'(H_ACTIVE + H_FP + H_SYNC));
   assign vs_act    = (v_cnt >= CNT_W'(V_ACTIVE + V_FP)) && (v_cnt < CNT_W'(V_ACTIVE + V_FP + V_SYNC));
   // The origin pixel already belongs to the frame whose mode is being latched.
   assign pat_mode  = at_origin ? pattern_en : pat_q;
   assign marker    = queue_data[16];

   always_comb begin
      bar_color = 16'h0000;
      case (bar_idx)
         3'd0: bar_color = 16'hFFFF;
         3'd1: bar_color = 16'hFFE0;
         3'd2: bar_color = 16'h07FF;
         3'd3: bar_color = 16'h07E0;
         3'd4: bar_color = 16'hF81F;
         3'd5: bar_color = 16'hF800;
         3'd6: bar_color = 16'h001F;
         default: bar_color = 16'h0000;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      pix     = 16'h0000;
      set_uf  = 1'b0;
      set_se  = 1'b0;
      run_now = 1'b0;
      if (pat_mode) begin
         state_d = ST_RESYNC;
         pop     = !queue_empty && !marker;
         pix     = bar_color;
      end else begin
         run_now = (state_q == ST_RUN) || (at_origin && !queue_empty && marker);
         if (!run_now) begin
            pop = !queue_empty && !marker;
         end else begin
            state_d = ST_RUN;
            if (active) begin
               if (queue_empty) begin
                  set_uf = 1'b1;
               end else if (marker != at_origin) begin
                  set_se  = 1'b1;
                  state_d = ST_RESYNC;
               end else begin
                  pix = queue_data[15:0];
                  pop = 1'b1;
               end
            end
         end
      end
   end

   // Gated so the FIFO sees no pop while the block is held in reset.
   assign queue_rd_en = pop & reset_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         bar_px      <= '0;
         bar_idx     <= '0;
         pat_q       <= 1'b0;
         state_q     <= ST_RESYNC;
         underflow   <= 1'b0;
         sync_err    <= 1'b0;
         LCD_DE      <= 1'b0;
         LCD_HSYNC   <= ~HSYNC_POL;
         LCD_VSYNC   <= ~VSYNC_POL;
         LCD_R       <= '0;
         LCD_G       <= '0;
         LCD_B       <= '0;
         frame_start <= 1'b0;
      end else begin
         if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
         if (h_last) begin
            bar_px  <= '0;
            bar_idx <= '0;
         end else if (bar_px == CNT_W'(BAR_W - 1)) begin
            bar_px  <= '0;
            bar_idx <= bar_idx + 1'b1;
         end else begin
            bar_px <= bar_px + 1'b1;
         end
         if (at_origin) pat_q <= pattern_en;
         state_q     <= state_d;
         underflow   <= set_uf | (underflow & ~clear_status);
         sync_err    <= set_se | (sync_err & ~clear_status);
         LCD_DE      <= active;
         LCD_HSYNC   <= hs_act ? HSYNC_POL : ~HSYNC_POL;
         LCD_VSYNC   <= vs_act ? VSYNC_POL : ~VSYNC_POL;
         {LCD_R, LCD_G, LCD_B} <= active ? pix : 16'h0000;
         frame_start <= at_origin;
      end
   end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: raster timing table, queue display, underflow, marker realignment,
// colour bars on a 16-pixel-wide instance, and asynchronous reset.
module tb_lcd_timing_gen;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        pattern_en = 1'b0;
   logic        clear_status = 1'b0;
   logic [16:0] queue_data;
   logic        queue_empty;
   logic        queue_rd_en, LCD_DE, LCD_HSYNC, LCD_VSYNC, frame_start, underflow, sync_err;
   logic [4:0]  LCD_R, LCD_B;
   logic [5:0]  LCD_G;

   logic        pattern_en_p = 1'b1;
   logic        clear_p = 1'b0;
   logic [16:0] qd_p = 17'h11234;
   logic        qe_p = 1'b0;
   logic        rd_p, de_p, hs_p, vs_p, fs_p, uf_p, se_p;
   logic [4:0]  r_p, b_p;
   logic [5:0]  g_p;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lcd_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut (
      .clk(clk), .reset_n(reset_n), .pattern_en(pattern_en), .clear_status(clear_status),
      .queue_data(queue_data), .queue_empty(queue_empty), .queue_rd_en(queue_rd_en),
      .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC),
      .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
      .frame_start(frame_start), .underflow(underflow), .sync_err(sync_err));

   lcd_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut_p (
      .clk(clk), .reset_n(reset_n), .pattern_en(pattern_en_p), .clear_status(clear_p),
      .queue_data(qd_p), .queue_empty(qe_p), .queue_rd_en(rd_p),
      .LCD_DE(de_p), .LCD_HSYNC(hs_p), .LCD_VSYNC(vs_p),
      .LCD_R(r_p), .LCD_G(g_p), .LCD_B(b_p),
      .frame_start(fs_p), .underflow(uf_p), .sync_err(se_p));

   // FIFO model: show-ahead head, pops on the clock edge where rd_en is high
   logic [16:0] fifo_mem [0:255];
   int          rd_ptr = 0;
   int          wr_ptr = 0;
   assign queue_data  = fifo_mem[rd_ptr[7:0]];
   assign queue_empty = (rd_ptr == wr_ptr);
   always @(posedge clk) if (queue_rd_en && !queue_empty) rd_ptr <= rd_ptr + 1;

   always @(negedge clk) begin
      if (reset_n && queue_empty) begin
         checks++;
         if (queue_rd_en) begin
            failures++;
            $display("FAIL pop_while_empty: queue_rd_en=1 required 0 at %0t", $time);
         end
      end
   end

   logic [15:0] rgb, rgb_p;
   assign rgb   = {LCD_R, LCD_G, LCD_B};
   assign rgb_p = {r_p, g_p, b_p};

   typedef struct {
      int          edge_n;
      logic        de, hs, vs, fs;
      logic [15:0] rgb;
   } vec_t;
   vec_t tv[11];

   logic [15:0] bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};
   logic [15:0] cap[64];
   logic [15:0] exp_pix[32];
   int          cap_n;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      clear_status = 1'b0;
   endtask

   task automatic push(input logic [16:0] w);
      fifo_mem[wr_ptr[7:0]] = w;
      wr_ptr++;
   endtask

   task automatic push_frame(input logic [15:0] base);
      for (int i = 0; i < 32; i++) begin
         push({(i == 0), base + 16'(i + 1)});
         exp_pix[i] = base + 16'(i + 1);
      end
   endtask

   // Waits for frame_start, then records every DE pixel of that frame (98 clocks).
   // If refill_pix >= 0, two non-marker words are pushed once refill_pix pixels are captured.
   task automatic capture_frame(input int refill_pix);
      bit got = 0;
      bit refilled = 0;
      cap_n = 0;
      for (int k = 0; k < 400 && !got; k++) begin
         step();
         if (frame_start) got = 1;
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL frame_start_timeout: no frame_start within 400 clocks");
         return;
      end
      for (int i = 0; i < 98; i++) begin
         if (i > 0) step();
         if (LCD_DE && cap_n < 64) begin
            cap[cap_n] = rgb;
            cap_n++;
         end
         if (!refilled && cap_n == refill_pix) begin
            push(17'h00B01);
            push(17'h00B02);
            refilled = 1;
         end
      end
   endtask

   task automatic compare_frame(input string name);
      chk({name, "_count"}, 32'(cap_n), 32);
      for (int i = 0; i < 32; i++) chk($sformatf("%s[%0d]", name, i), 32'(cap[i]), 32'(exp_pix[i]));
   endtask

   initial begin
      int edge_cnt, hs_lo, vs_lo, de_n, fs_n, col, pops, pdone;
      bit got;

      for (int i = 0; i < 256; i++) fifo_mem[i] = '0;
      tv[0]  = '{1,  1'b1, 1'b1, 1'b1, 1'b1, 16'h0};
      tv[1]  = '{2,  1'b1, 1'b1, 1'b1, 1'b0, 16'h0};
      tv[2]  = '{8,  1'b1, 1'b1, 1'b1, 1'b0, 16'h0};
      tv[3]  = '{9,  1'b0, 1'b1, 1'b1, 1'b0, 16'h0};
      tv[4]  = '{11, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0};
      tv[5]  = '{12, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0};
      tv[6]  = '{13, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0};
      tv[7]  = '{43, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0};
      tv[8]  = '{57, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0};
      tv[9]  = '{71, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0};
      tv[10] = '{99, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0};

      // Reset state
      #12;
      chk("rst_de", 32'(LCD_DE), 0);
      chk("rst_hsync", 32'(LCD_HSYNC), 1);
      chk("rst_vsync", 32'(LCD_VSYNC), 1);
      chk("rst_rgb", 32'(rgb), 0);
      chk("rst_fs", 32'(frame_start), 0);
      chk("rst_flags", 32'({underflow, sync_err}), 0);
      chk("rst_rd_en", 32'(queue_rd_en), 0);
      #10 reset_n = 1'b1;

      // Raster timing, queue empty
      edge_cnt = 0;
      for (int v = 0; v < 11; v++) begin
         while (edge_cnt < tv[v].edge_n) begin
            step();
            edge_cnt++;
         end
         chk($sformatf("tv%0d_de", v), 32'(LCD_DE), 32'(tv[v].de));
         chk($sformatf("tv%0d_hsync", v), 32'(LCD_HSYNC), 32'(tv[v].hs));
         chk($sformatf("tv%0d_vsync", v), 32'(LCD_VSYNC), 32'(tv[v].vs));
         chk($sformatf("tv%0d_fs", v), 32'(frame_start), 32'(tv[v].fs));
         chk($sformatf("tv%0d_rgb", v), 32'(rgb), 32'(tv[v].rgb));
      end
      hs_lo = 0; vs_lo = 0; de_n = 0; fs_n = 0;
      for (int i = 0; i < 98; i++) begin
         step();
         hs_lo += (LCD_HSYNC == 1'b0);
         vs_lo += (LCD_VSYNC == 1'b0);
         de_n  += LCD_DE;
         fs_n  += frame_start;
      end
      chk("frame_hsync_low", 32'(hs_lo), 14);
      chk("frame_vsync_low", 32'(vs_lo), 14);
      chk("frame_de_count", 32'(de_n), 32);
      chk("frame_fs_count", 32'(fs_n), 1);

      // Colour bars on the 16-wide instance
      got = 0;
      for (int k = 0; k < 400 && !got; k++) begin
         step();
         if (fs_p) got = 1;
      end
      chk("pat_fs_seen", 32'(got), 1);
      col = 0; pops = 0; pdone = 0;
      for (int i = 0; i < 154; i++) begin
         if (i > 0) step();
         pops += rd_p;
         if (de_p) begin
            chk($sformatf("pat_px%0d", pdone), 32'(rgb_p), 32'(bars[col / 2]));
            pdone++;
            col = (col == 15) ? 0 : col + 1;
         end
      end
      chk("pat_px_count", 32'(pdone), 64);
      chk("pat_no_pops", 32'(pops), 0);
      chk("pat_sync_err", 32'(se_p), 0);
      pattern_en_p = 1'b0;
      got = 0;
      for (int k = 0; k < 400 && !got; k++) begin
         step();
         if (fs_p) got = 1;
      end
      chk("pat_exit_fs", 32'(got), 1);
      chk("pat_exit_rgb", 32'(rgb_p), 32'h1234);

      // Full queue frame
      push_frame(16'h0000);
      capture_frame(-1);
      compare_frame("run");
      chk("run_flags", 32'({underflow, sync_err}), 0);
      chk("run_drained", 32'(queue_empty), 1);

      // Underflow after 5 pixels, refill after pixel 12
      push(17'h10A01);
      for (int i = 2; i <= 5; i++) push({1'b0, 16'h0A00 + 16'(i)});
      for (int i = 0; i < 32; i++) exp_pix[i] = 16'h0000;
      for (int i = 0; i < 5; i++) exp_pix[i] = 16'h0A01 + 16'(i);
      exp_pix[12] = 16'h0B01;
      exp_pix[13] = 16'h0B02;
      capture_frame(12);
      compare_frame("uf");
      chk("uf_underflow", 32'(underflow), 1);
      chk("uf_sync_err", 32'(sync_err), 0);

      // clear_status at the origin of a good frame
      push_frame(16'h0C00);
      clear_status = 1'b1;
      capture_frame(-1);
      compare_frame("clr");
      chk("clr_underflow", 32'(underflow), 0);

      // Marker on third word, then a good frame
      push(17'h10D01);
      push(17'h00D02);
      push_frame(16'h0E00);
      capture_frame(-1);
      chk("mk_px0", 32'(cap[0]), 32'h0D01);
      chk("mk_px1", 32'(cap[1]), 32'h0D02);
      pops = 0;
      for (int i = 2; i < 32; i++) pops += (cap[i] != 16'h0000);
      chk("mk_black_tail", 32'(pops), 0);
      chk("mk_sync_err", 32'(sync_err), 1);
      chk("mk_underflow", 32'(underflow), 0);
      capture_frame(-1);
      compare_frame("mk_next");

      // Asynchronous reset mid-line
      for (int i = 0; i < 4; i++) step();
      chk("pre_rst_de", 32'(LCD_DE), 1);
      chk("pre_rst_underflow", 32'(underflow), 1);
      reset_n = 1'b0;
      #1;
      chk("arst_de", 32'(LCD_DE), 0);
      chk("arst_sync", 32'({LCD_HSYNC, LCD_VSYNC}), 3);
      chk("arst_rgb", 32'(rgb), 0);
      chk("arst_flags", 32'({underflow, sync_err, frame_start}), 0);
      chk("arst_rd_en", 32'(queue_rd_en), 0);
      #2 reset_n = 1'b1;
      step();
      chk("rel_de", 32'(LCD_DE), 1);
      chk("rel_fs", 32'(frame_start), 1);
      step();
      chk("rel_fs_pulse", 32'(frame_start), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
